// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the AHB-to-UART byte-stream bridge.
// Register offsets, FSM states, register bit positions and hsize encodings.
package uart_bridge_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_IRQCFG = 2'd3;

   typedef enum logic [1:0] {IDLE, DATA, WAIT_TX, RESP} bridge_fsm_t;

   localparam int unsigned STAT_RX_NONEMPTY  = 0;
   localparam int unsigned STAT_TX_NOTFULL   = 1;
   localparam int unsigned STAT_TX_EMPTY     = 2;
   localparam int unsigned STAT_RX_COUNT_LSB = 8;
   localparam int unsigned STAT_TX_FREE_LSB  = 16;

   localparam int unsigned CTRL_TX_FLUSH = 0;
   localparam int unsigned CTRL_RX_FLUSH = 1;

   localparam int unsigned IRQ_RX_IE      = 0;
   localparam int unsigned IRQ_TX_IE      = 1;
   localparam int unsigned IRQ_THRESH_LSB = 8;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   function automatic logic [7:0] sat8(input logic [8:0] v);
      return v[8] ? 8'hff : v[7:0];
   endfunction

endpackage

// File: rtl/ahb_uart_bridge_v2_if.sv
// AHB slave-side bus bundle for the UART bridge.
interface ahb_uart_bridge_v2_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  hsel;
   logic                  hwrite;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [2:0]            hsize;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hready;
   logic                  hresp;
   logic [DATA_WIDTH-1:0] hrdata;

   modport master (
      output hsel, hwrite, haddr, hsize, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  hsel, hwrite, haddr, hsize, hwdata,
      output hready, hresp, hrdata
   );
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with an atomic multi-byte push (wr_n_i bytes, LSB lane first),
// single-byte first-word-fall-through pop, flush, and count/free outputs.
module uart_byte_fifo #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned WR_LANES = 1,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1,
   localparam int unsigned NW = $clog2(WR_LANES) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  wr_en_i,
   input  logic [NW-1:0]         wr_n_i,
   input  logic [8*WR_LANES-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [7:0]            rd_data_o,
   output logic [CW-1:0]         count_o,
   output logic [CW-1:0]         free_o,
   output logic                  empty_o,
   output logic                  full_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] push_amt;
   logic          do_push, do_pop;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CW'(DEPTH));
   assign free_o    = CW'(DEPTH) - count_q;
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Never a partial push: either all wr_n_i bytes fit or nothing is written.
      do_push  = wr_en_i && !flush_i && (CW'(wr_n_i) <= free_o);
      do_pop   = rd_en_i && !flush_i && !empty_o;
      push_amt = do_push ? CW'(wr_n_i) : '0;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            for (int i = 0; i < int'(WR_LANES); i++) begin
               if (i < int'(wr_n_i)) begin
                  mem_d[wr_ptr_q + PW'(i)] = wr_data_i[8*i +: 8];
               end
            end
            wr_ptr_d = wr_ptr_q + PW'(wr_n_i);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + push_amt - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ahb_uart_bridge_v2.sv
// AHB slave to UART byte-stream bridge with TX/RX byte FIFOs and status/flush registers.
// Optional IRQCFG register and irq output are enabled by defining UART_BRIDGE_IRQ_EN.
module ahb_uart_bridge_v2
   import uart_bridge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TX_DEPTH   = 16,
   parameter int unsigned RX_DEPTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   ahb_uart_bridge_v2_if.slave  bus,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 irq
);

   localparam int unsigned NBYTES  = DATA_WIDTH / 8;
   localparam int unsigned NW      = $clog2(NBYTES) + 1;
   localparam int unsigned MAXSIZE = $clog2(NBYTES);
   localparam int unsigned TXCW    = $clog2(TX_DEPTH) + 1;
   localparam int unsigned RXCW    = $clog2(RX_DEPTH) + 1;

   bridge_fsm_t           state_q, state_d;
   logic [1:0]            addr_q, addr_d;
   logic                  write_q, write_d;
   logic [2:0]            size_q, size_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  hready_q, hready_d;
   logic                  hresp_q, hresp_d;
   logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

   logic                  tx_push, tx_flush, tx_empty, tx_full, tx_fits;
   logic [NW-1:0]         tx_push_n;
   logic [DATA_WIDTH-1:0] tx_push_data;
   logic [TXCW-1:0]       tx_free, unused_tx_count;
   logic                  rx_pop, rx_flush, rx_empty, rx_full;
   logic [7:0]            rx_head;
   logic [RXCW-1:0]       rx_count, unused_rx_free;
   logic [DATA_WIDTH-1:0] status_word, rx_word;
   logic                  unused_addr;

   assign unused_addr = ^{bus.haddr[ADDR_WIDTH-1:4], bus.haddr[1:0]};
   assign bus.hready  = hready_q;
   assign bus.hresp   = hresp_q;
   assign bus.hrdata  = hrdata_q;
   assign tx_valid    = !tx_empty;
   assign rx_ready    = !rx_full;

`ifdef UART_BRIDGE_IRQ_EN
   logic                  rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
   logic [7:0]            rx_thresh_q, rx_thresh_d, thr;
   logic                  irq_q, irq_d, cfg_wr;
   logic [DATA_WIDTH-1:0] irqcfg_word;
`endif

   always_comb begin
      status_word = '0;
      status_word[STAT_RX_NONEMPTY] = !rx_empty;
      status_word[STAT_TX_NOTFULL]  = !tx_full;
      status_word[STAT_TX_EMPTY]    = tx_empty;
      status_word[STAT_RX_COUNT_LSB +: 8] = sat8(9'(rx_count));
      status_word[STAT_TX_FREE_LSB +: 8]  = sat8(9'(tx_free));
      rx_word = '0;
      rx_word[8] = rx_empty;
      if (!rx_empty) begin
         rx_word[7:0] = rx_head;
      end
   end

   // Stalled writes replay the held data/size from WAIT_TX.
   assign tx_push_n    = NW'(1) << size_q;
   assign tx_push_data = (state_q == DATA) ? bus.hwdata : wdata_q;
   assign tx_fits      = (32'(tx_push_n) <= 32'(tx_free));

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      write_d  = write_q;
      size_d   = size_q;
      wdata_d  = wdata_q;
      hready_d = 1'b0;
      hresp_d  = 1'b0;
      hrdata_d = hrdata_q;
      tx_push  = 1'b0;
      tx_flush = 1'b0;
      rx_pop   = 1'b0;
      rx_flush = 1'b0;
`ifdef UART_BRIDGE_IRQ_EN
      cfg_wr   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.hsel) begin
               addr_d  = bus.haddr[3:2];
               write_d = bus.hwrite;
               size_d  = bus.hsize;
               state_d = DATA;
            end
         end
         DATA: begin
            state_d  = RESP;
            hready_d = 1'b1;
            if (32'(size_q) > MAXSIZE) begin
               hresp_d = 1'b1;
            end else begin
               unique case (addr_q)
                  REG_DATA: begin
                     if (write_q) begin
                        wdata_d = bus.hwdata;
                        if (tx_fits) begin
                           tx_push = 1'b1;
                        end else begin
                           state_d  = WAIT_TX;
                           hready_d = 1'b0;
                        end
                     end else begin
                        hrdata_d = rx_word;
                        rx_pop   = !rx_empty;
                     end
                  end
                  REG_STATUS: begin
                     if (write_q) hresp_d = 1'b1;
                     else         hrdata_d = status_word;
                  end
                  REG_CTRL: begin
                     if (write_q) begin
                        tx_flush = bus.hwdata[CTRL_TX_FLUSH];
                        rx_flush = bus.hwdata[CTRL_RX_FLUSH];
                     end else begin
                        hresp_d = 1'b1;
                     end
                  end
                  REG_IRQCFG: begin
`ifdef UART_BRIDGE_IRQ_EN
                     if (write_q) cfg_wr = 1'b1;
                     else         hrdata_d = irqcfg_word;
`else
                     hresp_d = 1'b1;
`endif
                  end
               endcase
            end
         end
         WAIT_TX: begin
            if (tx_fits) begin
               tx_push  = 1'b1;
               state_d  = RESP;
               hready_d = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         size_q   <= '0;
         wdata_q  <= '0;
         hready_q <= 1'b0;
         hresp_q  <= 1'b0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         size_q   <= size_d;
         wdata_q  <= wdata_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
         hrdata_q <= hrdata_d;
      end
   end

`ifdef UART_BRIDGE_IRQ_EN
   always_comb begin
      irqcfg_word = '0;
      irqcfg_word[IRQ_RX_IE] = rx_ie_q;
      irqcfg_word[IRQ_TX_IE] = tx_ie_q;
      irqcfg_word[IRQ_THRESH_LSB +: 8] = rx_thresh_q;
      rx_ie_d     = rx_ie_q;
      tx_ie_d     = tx_ie_q;
      rx_thresh_d = rx_thresh_q;
      if (cfg_wr) begin
         rx_ie_d     = bus.hwdata[IRQ_RX_IE];
         tx_ie_d     = bus.hwdata[IRQ_TX_IE];
         rx_thresh_d = bus.hwdata[IRQ_THRESH_LSB +: 8];
      end
      // A threshold of zero behaves as one so an empty FIFO never interrupts.
      thr   = (rx_thresh_q == 8'd0) ? 8'd1 : rx_thresh_q;
      irq_d = (rx_ie_q && (9'(rx_count) >= {1'b0, thr})) || (tx_ie_q && tx_empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ie_q     <= 1'b0;
         tx_ie_q     <= 1'b0;
         rx_thresh_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         rx_ie_q     <= rx_ie_d;
         tx_ie_q     <= tx_ie_d;
         rx_thresh_q <= rx_thresh_d;
         irq_q       <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   uart_byte_fifo #(
      .DEPTH    (TX_DEPTH),
      .WR_LANES (NBYTES)
   ) u_tx_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .flush_i   (tx_flush),
      .wr_en_i   (tx_push),
      .wr_n_i    (tx_push_n),
      .wr_data_i (tx_push_data),
      .rd_en_i   (tx_ready),
      .rd_data_o (tx_data),
      .count_o   (unused_tx_count),
      .free_o    (tx_free),
      .empty_o   (tx_empty),
      .full_o    (tx_full)
   );

   uart_byte_fifo #(
      .DEPTH    (RX_DEPTH),
      .WR_LANES (1)
   ) u_rx_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .flush_i   (rx_flush),
      .wr_en_i   (rx_valid && rx_ready),
      .wr_n_i    (1'b1),
      .wr_data_i (rx_data),
      .rd_en_i   (rx_pop),
      .rd_data_o (rx_head),
      .count_o   (rx_count),
      .free_o    (unused_rx_free),
      .empty_o   (rx_empty),
      .full_o    (rx_full)
   );

endmodule
